// File: rtl/mips_rf_pkg.sv
// Shared types and helpers for the multi-port MIPS register file.
package mips_rf_pkg;

    // The sequencer is in CLEAR while it zeroes the array after reset, then in RUN.
    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    // Address width for a given entry count.
    // Never returns less than 1, so that a 1-entry array still has a legal address bus.
    function automatic int rf_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sequencer for the register file.
// It sweeps every entry once, writing zero to each, and then raises ready.
module regfile_clr_seq
    import mips_rf_pkg::*;
#(
    parameter  int DEPTH = 32,
    localparam int AW    = rf_addr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic          ready,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    rf_state_t     state, state_nx;
    logic [AW-1:0] ptr, ptr_nx;

    // State and pointer register. Reset is synchronous, so every sweep restarts at entry 0.
    // NOTE: sequential state uses non-blocking (<=) so all flops update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= RF_CLEAR;
            ptr   <= '0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
        end
    end

    // Next-state and sweep outputs.
    // The pointer holds at DEPTH-1 on the final clear cycle, so it never wraps.
    // NOTE: every output gets a default first, so no path leaves a value unassigned (no latch).
    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        clr_we   = 1'b0;
        clr_addr = ptr;
        ready    = 1'b0;
        case (state)
            RF_CLEAR: begin
                clr_we = 1'b1;
                if (ptr == LAST) begin
                    state_nx = RF_RUN;
                end else begin
                    ptr_nx = ptr + 1'b1;
                end
            end
            RF_RUN: begin
                ready = 1'b1;
            end
            default: begin
                state_nx = RF_CLEAR;
            end
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file: 2 combinational read ports and 2 clocked write ports.
// Write port 1 wins when both ports write the same address.
// Optional same-cycle write-to-read bypass and an optional hardwired-zero entry 0.
module regfile_mp
    import mips_rf_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int DEPTH   = 32,
    parameter  bit R0_ZERO = 1'b1,
    parameter  bit BYPASS  = 1'b1,
    localparam int AW      = rf_addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             ready,
    input  logic             we0,
    input  logic [AW-1:0]    wa0,
    input  logic [WIDTH-1:0] wd0,
    input  logic             we1,
    input  logic [AW-1:0]    wa1,
    input  logic [WIDTH-1:0] wd1,
    input  logic [AW-1:0]    ra0,
    input  logic [AW-1:0]    ra1,
    output logic [WIDTH-1:0] rd0,
    output logic [WIDTH-1:0] rd1
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic          clr_we;
    logic [AW-1:0] clr_addr;
    logic          commit0, commit1;
    logic [AW-1:0] ra [2];
    logic [WIDTH-1:0] rd [2];

    regfile_clr_seq #(
        .DEPTH (DEPTH)
    ) u_clr_seq (
        .clk      (clk),
        .reset_n  (reset_n),
        .ready    (ready),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    // Write qualification.
    // Port 0 yields to port 1 on an address collision.
    // When R0_ZERO is set, writes to entry 0 are dropped.
    always_comb begin
        commit0 = we0 && !(we1 && (wa1 == wa0)) && !(R0_ZERO && (wa0 == '0));
        commit1 = we1 && !(R0_ZERO && (wa1 == '0));
    end

    // Storage write mux.
    // During the sweep only the clear write lands; the ports are ignored.
    // Nothing is written on a reset edge.
    // NOTE: the array has no reset term; it is cleared by the sweep, which keeps it a plain RAM.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (clr_we) begin
                mem[clr_addr] <= '0;
            end else begin
                if (commit0) mem[wa0] <= wd0;
                if (commit1) mem[wa1] <= wd1;
            end
        end
    end

    // Gather the read addresses so both ports share one mux description.
    always_comb begin
        ra[0] = ra0;
        ra[1] = ra1;
    end

    // Read muxes.
    // With BYPASS set, port 1's same-cycle write is forwarded first, then port 0's.
    // Output is 0 until ready, and 0 for entry 0 when R0_ZERO is set.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd[p] = mem[ra[p]];
            if (BYPASS) begin
                if (we1 && (wa1 == ra[p])) begin
                    rd[p] = wd1;
                end else if (we0 && (wa0 == ra[p])) begin
                    rd[p] = wd0;
                end
            end
            if (!ready || (R0_ZERO && (ra[p] == '0))) begin
                rd[p] = '0;
            end
        end
    end

    assign rd0 = rd[0];
    assign rd1 = rd[1];

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port register file, the next-generation integer register file for the MIPS datapath. It has 2 combinational read ports and 2 clocked write ports with fixed write priority. Optional same-cycle write-to-read bypass and an optional hardwired-zero entry are selected by parameter. A post-reset clear sequencer zeroes every entry before the block reports ready, so the datapath never reads X after reset.

Parameters:
WIDTH, 32, data bits per entry
DEPTH, 32, number of entries; power of 2, at least 2; AW = log2(DEPTH)
R0_ZERO, 1, when 1, entry 0 reads as 0 and writes to it are dropped
BYPASS, 1, when 1, a same-cycle write is forwarded to a matching read port

Ports:
clk  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset
ready  out  1  high once the clear sweep has completed
we0  in  1  write enable, port 0
wa0  in  AW  write address, port 0
wd0  in  WIDTH  write data, port 0
we1  in  1  write enable, port 1 (higher priority)
wa1  in  AW  write address, port 1
wd1  in  WIDTH  write data, port 1
ra0  in  AW  read address, port 0
ra1  in  AW  read address, port 1
rd0  out  WIDTH  read data, port 0 (combinational)
rd1  out  WIDTH  read data, port 1 (combinational)

Behaviour:
- Reset: any clock edge with reset_n=0 sets state CLEAR, clear pointer to 0 and ready to 0.
- Reset is honoured mid-sweep and mid-operation: the sweep restarts at entry 0.
- State CLEAR:
  - Each cycle writes 0 to entry[ptr], then ptr increments.
  - At ptr = DEPTH-1 the write happens, the state moves to RUN and ready goes to 1 on that edge.
  - The sweep therefore takes DEPTH cycles after reset_n rises.
  - we0/we1 are ignored; the caller must stall until ready=1.
- While ready=0: rd0 and rd1 = 0 regardless of address or bypass.
- State RUN: writes commit on the rising edge.
  - we0 alone: entry[wa0] <= wd0.
  - we1 alone: entry[wa1] <= wd1.
  - Both, wa0 != wa1: both commit.
  - Both, wa0 == wa1: only wd1 commits (port 1 wins).
- R0_ZERO=1:
  - Writes addressed to 0 are dropped.
  - Reads of address 0 return 0, including under bypass.
- Read with BYPASS=0: rdN = entry[raN]. A write becomes visible the cycle after its edge.
- Read with BYPASS=1, in priority order:
  - if we1 and wa1 == raN, rdN = wd1;
  - else if we0 and wa0 == raN, rdN = wd0;
  - else rdN = entry[raN].
  - Bypass applies only when ready=1, and never to address 0 when R0_ZERO=1.
- No arithmetic; all data paths are WIDTH bits. The pointer is AW bits and must not wrap past DEPTH-1 in CLEAR.
- The state register is 1 bit (CLEAR/RUN); RUN persists until the next reset.

Decomposition:
- Package mips_rf_pkg:
  - typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;
  - function clog2-based address-width helper.
- One sub-module, regfile_clr_seq, parameter DEPTH:
  - Owns state, the pointer and ready.
  - Outputs clr_we and clr_addr to the storage write mux.
- The storage array, write-priority logic and read/bypass muxes stay in regfile_mp.

Test Plan:
- Reset sweep (DEPTH=32): hold reset_n=0 for 3 cycles, then release -> ready=0 for exactly 32 cycles then 1. Afterwards every address 0..31 reads 0x00000000 on both ports.
- Dual write, distinct addresses: we0 wa0=5 wd0=0x1111_1111 and we1 wa1=6 wd1=0x2222_2222 on one edge -> next cycle ra0=5 gives 0x11111111 and ra1=6 gives 0x22222222.
- Write collision: we0 and we1 both to address 9, wd0=0xAAAA_AAAA, wd1=0x5555_5555 -> entry 9 reads 0x55555555.
- Bypass (BYPASS=1): the same cycle as we1 wa1=3 wd1=0xDEAD_BEEF, drive ra0=3 -> rd0=0xDEADBEEF before the edge. With BYPASS=0, rd0 shows the old value (0) until the next cycle.
- R0 handling (R0_ZERO=1, BYPASS=1): we0 wa0=0 wd0=0xFFFF_FFFF with ra1=0 -> rd1=0 that cycle and every following cycle.
- Reset mid-sweep: drop reset_n for 1 cycle at sweep cycle 10 with we0 asserted -> ready stays 0 for a full 32 further cycles, and the write is not committed.
